// File: rtl/gpio_pulse_monitor.sv
// gpio_pulse_monitor
//   Counts full high-then-low pulses on NCH asynchronous GPIO pads during a
//   timed run. The run passes once every channel has produced BLINKS pulses,
//   or fails if TIMEOUT cycles elapse first.
//
// Ports
//   clock     sole clock, rising edge
//   reset     synchronous, active-high
//   start     one-cycle request: clear counts and (re)start a run
//   abort     end the current run, return to IDLE, hold counts
//   gpio_in   asynchronous pad levels; anything other than 1 reads as 0
//   count_o   per-channel pulse counts, channel 0 in the LSBs
//   cycles_o  cycles elapsed in the current/last run
//   busy      run in progress
//   pass      sticky: all channels reached BLINKS
//   fail      sticky: TIMEOUT reached first
//
// Build option
//   GPIO_PULSE_MONITOR_GLITCH_FILTER_EN: adds a per-channel filter that
//   accepts a new level only after FILT consecutive equal synchronized
//   samples (pad-to-count latency 3+FILT instead of 3).
module gpio_pulse_monitor #(
    parameter int unsigned NCH     = 1,
    parameter int unsigned BLINKS  = 10,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned TMO_W   = 17,
    parameter int unsigned FILT    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NCH-1:0]         gpio_in,
    output logic [NCH*CNT_W-1:0]   count_o,
    output logic [TMO_W-1:0]       cycles_o,
    output logic                   busy,
    output logic                   pass,
    output logic                   fail
);

    // Elaboration-time parameter legality checks.
    if (NCH < 1 || NCH > 32) begin : g_bad_nch
        $error("NCH must be 1..32");
    end
    if (BLINKS < 1 || BLINKS >= (64'd1 << CNT_W)) begin : g_bad_blinks
        $error("BLINKS must be 1..2^CNT_W-1");
    end
    if (TIMEOUT < 1 || TIMEOUT >= (64'd1 << TMO_W)) begin : g_bad_timeout
        $error("TIMEOUT must be 1..2^TMO_W-1");
    end
    if (FILT < 1) begin : g_bad_filt
        $error("FILT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t                      state_q, state_d;
    logic [NCH-1:0]              sync1_q, sync1_d;
    logic [NCH-1:0]              sync2_q, sync2_d;
    logic [NCH-1:0]              level;
    logic [NCH-1:0]              prev_q, prev_d;
    logic [NCH-1:0]              armed_q, armed_d;
    logic [NCH-1:0]              fall;
    logic [NCH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]            cycles_q, cycles_d;
    logic                        all_done_q;
    logic                        all_done_d;

    // Two-flop synchronizer. X/Z on the pad are folded to 0 here so
    // they can never arm or clock a channel.
    always_comb begin
        sync1_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            sync1_d[i] = (gpio_in[i] === 1'b1);
        end
        sync2_d = sync1_q;
    end

`ifdef GPIO_PULSE_MONITOR_GLITCH_FILTER_EN
    localparam int unsigned FW = $clog2(FILT + 1);

    logic [NCH-1:0][FW-1:0] fcnt_q, fcnt_d;
    logic [NCH-1:0]         flvl_q, flvl_d;

    // fcnt counts consecutive samples that disagree with the accepted level;
    // the FILT-th disagreeing sample flips the accepted level.
    always_comb begin
        flvl_d = flvl_q;
        fcnt_d = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (sync2_q[i] != flvl_q[i]) begin
                if (fcnt_q[i] == FW'(FILT - 1)) begin
                    flvl_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fcnt_q <= '0;
            flvl_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            flvl_q <= flvl_d;
        end
    end

    assign level = flvl_q;
`else
    assign level = sync2_q;
`endif

    assign fall = prev_q & ~level;

    always_comb begin
        all_done_q = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cnt_q[i] != CNT_W'(BLINKS)) begin
                all_done_q = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cycles_d   = cycles_q;
        armed_d    = armed_q;
        prev_d     = level;
        all_done_d = 1'b1;

        // A channel arms once it is seen high inside the run; only an armed
        // channel's falling edge counts, so a channel low at start needs a
        // rise first.
        if (state_q == S_RUN && !abort) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                if (level[i]) begin
                    armed_d[i] = 1'b1;
                end
                if (fall[i] && armed_q[i] && cnt_q[i] != CNT_W'(BLINKS)) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end

        for (int unsigned i = 0; i < NCH; i++) begin
            if (cnt_d[i] != CNT_W'(BLINKS)) begin
                all_done_d = 1'b0;
            end
        end

        if (start) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            cycles_d = '0;
            armed_d  = '0;
        end else if (state_q == S_RUN) begin
            if (abort) begin
                state_d = S_IDLE;
            end else if (all_done_q) begin
                state_d = S_PASS;
            end else if (cycles_q == TMO_W'(TIMEOUT - 1)) begin
                // A completion landing on the timeout edge still passes.
                state_d = all_done_d ? S_PASS : S_FAIL;
            end else if (cycles_q != {TMO_W{1'b1}}) begin
                cycles_d = cycles_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            armed_q  <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            armed_q  <= armed_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign count_o  = cnt_q;
    assign cycles_o = cycles_q;
    assign busy     = (state_q == S_RUN);
    assign pass     = (state_q == S_PASS);
    assign fail     = (state_q == S_FAIL);

endmodule

// File: tb/tb_gpio_pulse_monitor.sv
// Self-checking bench for gpio_pulse_monitor: two channels, BLINKS=10,
// TIMEOUT=1000. Expected counts are pushed on each driven falling edge and
// popped when the DUT should have produced them.
module tb_gpio_pulse_monitor;

    localparam int NCH     = 2;
    localparam int BLINKS  = 10;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 1000;
    localparam int TMO_W   = 10;
    localparam int FILT    = 4;
`ifdef GPIO_PULSE_MONITOR_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILT;
`else
    localparam int LAT = 3;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [NCH-1:0]       gpio_in;
    logic [NCH*CNT_W-1:0] count_o;
    logic [TMO_W-1:0]     cycles_o;
    logic                 busy;
    logic                 pass;
    logic                 fail;

    gpio_pulse_monitor #(
        .NCH(NCH), .BLINKS(BLINKS), .CNT_W(CNT_W),
        .TIMEOUT(TIMEOUT), .TMO_W(TMO_W), .FILT(FILT)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .gpio_in(gpio_in), .count_o(count_o), .cycles_o(cycles_o),
        .busy(busy), .pass(pass), .fail(fail)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          exp_cnt [NCH];
    bit          armed   [NCH];
    bit          running;
    int          start_edge;
    int          last_fall_edge;
    logic [15:0] sb_q [$];

    always @(negedge clock) begin
        if (reset === 1'b0) begin
            checks++;
            if (pass === 1'b1 && fail === 1'b1) begin
                errors++;
                $display("FAIL pass_fail_exclusive: pass=%b fail=%b expected not both 1", pass, fail);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start(input bit with_abort);
        start = 1'b1;
        abort = with_abort;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        start_edge = edge_cnt;
        running = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            exp_cnt[c] = 0;
            armed[c]   = 1'b0;
        end
    endtask

    task automatic set_high(input logic [NCH-1:0] mask);
        gpio_in = gpio_in | mask;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c] && running) armed[c] = 1'b1;
        end
    endtask

    task automatic set_low(input logic [NCH-1:0] mask);
        logic [15:0] e;
        for (int c = 0; c < NCH; c++) begin
            if (mask[c] && gpio_in[c] === 1'b1 && running && armed[c] && exp_cnt[c] < BLINKS)
                exp_cnt[c]++;
        end
        gpio_in = gpio_in & ~mask;
        last_fall_edge = edge_cnt;
        e = {8'(exp_cnt[1]), 8'(exp_cnt[0])};
        sb_q.push_back(e);
    endtask

    task automatic check_sb();
        logic [15:0] e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got count %h with no expected entry", count_o);
        end else begin
            e = sb_q.pop_front();
            if (count_o !== e) begin
                errors++;
                $display("FAIL pulse_count: got %h expected %h", count_o, e);
            end
        end
    endtask

    task automatic pulse(input logic [NCH-1:0] mask, input int hi, input int lo);
        set_high(mask);
        tick(hi);
        set_low(mask);
        tick(LAT);
        check_sb();
        tick(lo - LAT);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; gpio_in = '0;
        running = 1'b0;
        tick(3);
        checks++;
        if ({count_o, cycles_o, busy, pass, fail} !== '0) begin
            errors++;
            $display("FAIL reset_state: got count=%h cycles=%0d busy=%b pass=%b fail=%b expected all 0",
                     count_o, cycles_o, busy, pass, fail);
        end
        reset = 1'b0;
        tick(2);
    endtask

    task automatic test_latency();
        do_start(1'b0);
        checks++;
        if (busy !== 1'b1 || cycles_o !== 10'd0 || count_o !== 16'h0) begin
            errors++;
            $display("FAIL start_state: got busy=%b cycles=%0d count=%h expected 1/0/0000", busy, cycles_o, count_o);
        end
        set_high(2'b01);
        tick(20);
        set_low(2'b01);
        tick(LAT - 1);
        checks++;
        if (count_o !== 16'h0000) begin
            errors++;
            $display("FAIL latency_early: got %h expected 0000", count_o);
        end
        tick(1);
        check_sb();
        tick(10);
    endtask

    task automatic test_pass();
        int exp_cyc;
        do_start(1'b0);
        for (int p = 0; p < 10; p++) pulse(2'b11, 20, 20);
        exp_cyc = last_fall_edge + LAT - start_edge;
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || count_o !== 16'h0a0a) begin
            errors++;
            $display("FAIL pass_run: got pass=%b fail=%b busy=%b count=%h expected 1/0/0/0a0a",
                     pass, fail, busy, count_o);
        end
        tick(5);
        checks++;
        if (cycles_o !== 10'(exp_cyc)) begin
            errors++;
            $display("FAIL pass_cycles_frozen: got %0d expected %0d", cycles_o, exp_cyc);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_start(1'b0);
        for (int p = 0; p < 9; p++) pulse(2'b11, 20, 20);
        pulse(2'b01, 20, 20);
        while (fail !== 1'b1 && n < 1200) begin
            tick(1);
            n++;
        end
        running = 1'b0;
        checks++;
        if (fail !== 1'b1 || edge_cnt - start_edge != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_edge: got fail=%b after %0d cycles expected 1 after %0d",
                     fail, edge_cnt - start_edge, TIMEOUT);
        end
        checks++;
        if (cycles_o !== 10'd999 || count_o !== 16'h090a || pass !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_state: got cycles=%0d count=%h pass=%b busy=%b expected 999/090a/0/0",
                     cycles_o, count_o, pass, busy);
        end
    endtask

    task automatic test_timeout_boundary();
        do_start(1'b0);
        for (int p = 0; p < 9; p++) pulse(2'b11, 20, 20);
        pulse(2'b10, 20, 20);
        set_high(2'b01);
        while (edge_cnt < start_edge + TIMEOUT - LAT) tick(1);
        set_low(2'b01);
        tick(LAT);
        check_sb();
        checks++;
        if (pass !== 1'b1 || fail !== 1'b0 || cycles_o !== 10'd999 || busy !== 1'b0) begin
            errors++;
            $display("FAIL pass_on_timeout: got pass=%b fail=%b cycles=%0d busy=%b expected 1/0/999/0",
                     pass, fail, cycles_o, busy);
        end
    endtask

    task automatic test_x_saturate();
        do_start(1'b0);
        gpio_in = 'x;
        tick(50);
        gpio_in = '0;
        tick(10);
        checks++;
        if (count_o !== 16'h0000) begin
            errors++;
            $display("FAIL x_input: got %h expected 0000", count_o);
        end
        for (int p = 0; p < 12; p++) pulse(2'b01, 20, 20);
        checks++;
        if (count_o !== 16'h000a || busy !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL saturate: got count=%h busy=%b pass=%b expected 000a/1/0", count_o, busy, pass);
        end
    endtask

    task automatic test_abort_reset();
        int exp_cyc;
        do_start(1'b0);
        for (int p = 0; p < 4; p++) pulse(2'b01, 20, 20);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        running = 1'b0;
        exp_cyc = edge_cnt - 1 - start_edge;
        checks++;
        if (busy !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || count_o !== 16'h0004 ||
            cycles_o !== 10'(exp_cyc)) begin
            errors++;
            $display("FAIL abort: got busy=%b pass=%b fail=%b count=%h cycles=%0d expected 0/0/0/0004/%0d",
                     busy, pass, fail, count_o, cycles_o, exp_cyc);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        pulse(2'b01, 20, 20);
        checks++;
        if (busy !== 1'b0 || cycles_o !== 10'(exp_cyc)) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b cycles=%0d expected 0/%0d", busy, cycles_o, exp_cyc);
        end
        do_start(1'b0);
        for (int p = 0; p < 2; p++) pulse(2'b01, 20, 20);
        set_high(2'b11);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        gpio_in = '0;
        running = 1'b0;
        checks++;
        if ({count_o, cycles_o, busy, pass, fail} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got count=%h cycles=%0d busy=%b pass=%b fail=%b expected all 0",
                     count_o, cycles_o, busy, pass, fail);
        end
        tick(10);
    endtask

    task automatic test_restart();
        do_start(1'b0);
        for (int p = 0; p < 10; p++) pulse(2'b11, 20, 20);
        do_start(1'b0);
        checks++;
        if (busy !== 1'b1 || pass !== 1'b0 || count_o !== 16'h0 || cycles_o !== 10'd0) begin
            errors++;
            $display("FAIL restart_from_pass: got busy=%b pass=%b count=%h cycles=%0d expected 1/0/0000/0",
                     busy, pass, count_o, cycles_o);
        end
        pulse(2'b01, 20, 20);
        do_start(1'b1);
        checks++;
        if (busy !== 1'b1 || cycles_o !== 10'd0 || count_o !== 16'h0) begin
            errors++;
            $display("FAIL start_beats_abort: got busy=%b cycles=%0d count=%h expected 1/0/0000",
                     busy, cycles_o, count_o);
        end
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        running = 1'b0;
    endtask

`ifdef GPIO_PULSE_MONITOR_GLITCH_FILTER_EN
    task automatic test_glitch();
        do_start(1'b0);
        pulse(2'b01, 20, 20);
        gpio_in = 2'b01;
        tick(2);
        gpio_in = 2'b00;
        tick(20);
        checks++;
        if (count_o !== 16'h0001) begin
            errors++;
            $display("FAIL glitch_rejected: got %h expected 0001", count_o);
        end
        set_high(2'b01);
        tick(6);
        set_low(2'b01);
        tick(LAT - 1);
        checks++;
        if (count_o !== 16'h0001) begin
            errors++;
            $display("FAIL filter_latency_early: got %h expected 0001", count_o);
        end
        tick(1);
        check_sb();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        running = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_pass();
        test_timeout();
        test_timeout_boundary();
        test_x_saturate();
        test_abort_reset();
        test_restart();
`ifdef GPIO_PULSE_MONITOR_GLITCH_FILTER_EN
        test_glitch();
`endif
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_pulse_monitor.md
GPIO_PULSE_MONITOR -- requirements
Module: gpio_pulse_monitor

Interface
REQ-001 Parameter NCH, default 1, number of monitored GPIO channels (1..32).
REQ-002 Parameter BLINKS, default 10, full high-then-low pulses required per channel for pass.
REQ-003 Parameter CNT_W, default 8, per-channel pulse counter width; BLINKS SHALL be < 2^CNT_W.
REQ-004 Parameter TIMEOUT, default 100000, clock cycles allowed per run before fail.
REQ-005 Parameter TMO_W, default 17, elapsed-cycle counter width; TIMEOUT SHALL be < 2^TMO_W.
REQ-006 Parameter FILT, default 4, stable-level cycles required by the glitch filter.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clock  input  1  sole clock, all logic on rising edge.
REQ-009 reset  input  1  synchronous active-high reset.
REQ-010 start  input  1  one-cycle request: clear counts, begin a run.
REQ-011 abort  input  1  end current run, return to IDLE, hold counts.
REQ-012 gpio_in  input  NCH  asynchronous monitored pad levels.
REQ-013 count_o  output  NCH*CNT_W  per-channel pulse counts, channel 0 in LSBs.
REQ-014 cycles_o  output  TMO_W  cycles elapsed in current/last run.
REQ-015 busy  output  1  high in RUN state.
REQ-016 pass  output  1  sticky; all channels reached BLINKS.
REQ-017 fail  output  1  sticky; TIMEOUT reached first.

Function
REQ-018 Each gpio_in bit SHALL pass a 2-flop synchronizer; any non-1 value (0, X, Z) SHALL be treated as 0.
REQ-019 A pulse SHALL count on a synchronized 1->0 transition preceded by a 1 level seen within the run; a channel low at start needs a rise first.
REQ-020 Without filter, count_o SHALL update 3 cycles after the pad falling edge.
REQ-021 FSM states: IDLE, RUN, PASS, FAIL; reset state IDLE.
REQ-022 IDLE->RUN on start: counts, cycles_o, pass, fail cleared the same edge.
REQ-023 RUN: cycles_o increments every cycle, saturating at 2^TMO_W-1.
REQ-024 Per-channel counters SHALL saturate at BLINKS; further pulses on that channel ignored.
REQ-025 RUN->PASS the cycle after the last channel reaches BLINKS; pass=1, cycles_o frozen.
REQ-026 RUN->FAIL when cycles_o == TIMEOUT-1 and not all channels done; fail=1.
REQ-027 Completion and timeout on the same cycle: PASS wins.
REQ-028 abort in RUN -> IDLE next cycle, counts and cycles_o held, pass=fail=0; abort outside RUN ignored.
REQ-029 start in RUN, PASS or FAIL SHALL restart (clear and enter RUN); start and abort together: start wins.
REQ-030 pass and fail SHALL never be high simultaneously.

Reset
REQ-031 On reset: state IDLE, count_o=0, cycles_o=0, busy=0, pass=0, fail=0, synchronizer and filter flops 0.
REQ-032 Reset mid-run SHALL discard the run with no pass/fail indication.

Configuration
REQ-033 Macro GPIO_PULSE_MONITOR_GLITCH_FILTER_EN, when defined, inserts per-channel filter: level accepted only after FILT consecutive equal synchronized samples; latency becomes 3+FILT cycles.
REQ-034 Without the macro, no filter logic; FILT unused; latency per REQ-020.

Verification
REQ-035 NCH=1, BLINKS=10: start, 10 pulses of 20 high/20 low cycles -> count_o=10, pass=1, fail=0, busy=0.
REQ-036 NCH=2, TIMEOUT=1000: ch0 10 pulses, ch1 9 -> fail=1 at cycles_o=999, count_o={9,10}.
REQ-037 Last pulse completes on the timeout cycle -> pass=1, fail=0.
REQ-038 gpio_in=X for 50 cycles then 0 -> no count; 12 pulses -> count saturates at 10.
REQ-039 abort after 4 pulses -> IDLE, count_o=4 held; reset mid-run -> all outputs 0.
REQ-040 Filter enabled, FILT=4: 2-cycle high glitch -> no count; 6-cycle pulse -> count +1, 7 cycles after fall.
